// File: rtl/adc_scan_control.sv
// adc_scan_control
// Scan sequencer for an ADS7843-class serial touch/sensor ADC. On a host
// start pulse or a pen-down interrupt it converts channels 0..NUM_CH-1, one
// 24-DCLK frame per channel (or four frames per channel when averaging is
// enabled). Each result leaves as a tagged stream word.
//
// Optional build macro: ADC_SCAN_AVG_EN
//   defined   : four frames per channel are summed and the sum is shifted
//               right by 2; one result is produced per channel
//   undefined : one frame per channel and no accumulator
//
// Ports
//   iCLK           system clock, rising edge
//   iRST           synchronous reset, active-high
//   iSTART         one-cycle scan request
//   iADC_PENIRQ_n  pen-down from the ADC, asynchronous, active-low
//   iADC_BUSY      ADC busy flag, monitored only (no effect on timing)
//   iADC_DOUT      ADC serial data
//   oADC_CS        chip select, active-low
//   oADC_DCLK      serial clock, idles low
//   oADC_DIN       serial control data to the ADC
//   oDATA          conversion result (RES bits)
//   oCH            channel tag of oDATA
//   oVALID         one-cycle result strobe
//   oSCAN_DONE     one-cycle pulse after the last channel
//   oBUSY          high from scan start through the oSCAN_DONE cycle
//
// FSM states
//   state   | meaning
//   S_IDLE  | waiting for iSTART or synchronised pen-down
//   S_FRAME | CS low, 24 DCLK periods: control byte out, result in
//   S_GAP   | CS high for GAP_CYC cycles between frames
//   S_DONE  | scan-done pulse, then back to idle

module adc_scan_control #(
  parameter int NUM_CH  = 2,
  parameter int RES     = 12,
  parameter int CLK_DIV = 25,
  parameter int GAP_CYC = 4
) (
  input  logic           iCLK,
  input  logic           iRST,
  input  logic           iSTART,
  input  logic           iADC_PENIRQ_n,
  input  logic           iADC_BUSY,
  input  logic           iADC_DOUT,
  output logic           oADC_CS,
  output logic           oADC_DCLK,
  output logic           oADC_DIN,
  output logic [RES-1:0] oDATA,
  output logic [2:0]     oCH,
  output logic           oVALID,
  output logic           oSCAN_DONE,
  output logic           oBUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRAME,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic           MODE_BIT  = (RES == 8);
  localparam logic [2:0]     LAST_CH   = 3'(NUM_CH - 1);
  localparam int             TMR_MAX   = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int             TW        = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0]  DIV_LOAD  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0]  GAP_LOAD  = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0]  TMR_ONE   = TW'(1);
  localparam logic [4:0]     SMP_FIRST = 5'd9;
  localparam logic [4:0]     SMP_LAST  = 5'(8 + RES);
  localparam logic [5:0]     HALF_LAST = 6'd47;

  // Channel n maps to ADC address {n[0], n[2:1]+1}, so ch0/ch1 land on the
  // X/Y pair (001/101) of the original touch controller. Differential mode,
  // power-down between conversions.
  function automatic logic [7:0] ctrl_byte(input logic [2:0] ch_sel);
    ctrl_byte = {1'b1, ch_sel[0], ch_sel[2:1] + 2'd1, MODE_BIT, 1'b0, 2'b00};
  endfunction

  state_t          state;
  logic            pen_s1;
  logic            pen_s2;
  logic [TW-1:0]   tmr;
  logic [5:0]      half;
  logic [4:0]      period;
  logic [7:0]      ctrl_sr;
  logic [RES-1:0]  shreg;
  logic [2:0]      ch;
  logic [2:0]      next_ch;
  logic            start_req;
  logic            smp_en;
  logic            ch_fin;
  logic            adc_busy_unused;

  assign adc_busy_unused = iADC_BUSY;
  assign start_req       = iSTART | ~pen_s2;
  assign period          = half[5:1];
  // Even half-period boundaries are DCLK rising edges.
  assign smp_en          = ~half[0] && (period >= SMP_FIRST) && (period <= SMP_LAST);
  assign next_ch         = ch_fin ? ch + 3'd1 : ch;

`ifdef ADC_SCAN_AVG_EN
  logic [1:0]     rep;
  logic [RES+1:0] acc;
  logic [RES+1:0] acc_sum;

  assign acc_sum = acc + {2'b00, shreg};
  // rep wraps to 0 after the fourth frame of a channel.
  assign ch_fin  = (rep == 2'd0);
`else
  assign ch_fin  = 1'b1;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= S_IDLE;
      pen_s1     <= 1'b1;
      pen_s2     <= 1'b1;
      tmr        <= '0;
      half       <= '0;
      ctrl_sr    <= '0;
      shreg      <= '0;
      ch         <= '0;
      oADC_CS    <= 1'b1;
      oADC_DCLK  <= 1'b0;
      oADC_DIN   <= 1'b0;
      oDATA      <= '0;
      oCH        <= '0;
      oVALID     <= 1'b0;
      oSCAN_DONE <= 1'b0;
      oBUSY      <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      rep        <= '0;
      acc        <= '0;
`endif
    end else begin
      pen_s1     <= iADC_PENIRQ_n;
      pen_s2     <= pen_s1;
      oVALID     <= 1'b0;
      oSCAN_DONE <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_req) begin
            state    <= S_FRAME;
            ch       <= '0;
            ctrl_sr  <= ctrl_byte(3'd0);
            oADC_CS  <= 1'b0;
            oADC_DIN <= 1'b1;        // control bit 7 is the start bit
            oBUSY    <= 1'b1;
            tmr      <= DIV_LOAD;
            half     <= '0;
`ifdef ADC_SCAN_AVG_EN
            rep      <= '0;
            acc      <= '0;
`endif
          end
        end

        S_FRAME: begin
          if (tmr != '0) begin
            tmr <= tmr - TMR_ONE;
          end else begin
            tmr  <= DIV_LOAD;
            half <= half + 6'd1;
            if (!half[0]) begin
              oADC_DCLK <= 1'b1;
              if (smp_en) begin
                shreg <= {shreg[RES-2:0], iADC_DOUT};
              end
            end else begin
              oADC_DCLK <= 1'b0;
              oADC_DIN  <= ctrl_sr[6];
              ctrl_sr   <= {ctrl_sr[6:0], 1'b0};
              // The 24th DCLK fall and the CS rise share an edge, so CS is
              // low for exactly 48*CLK_DIV cycles.
              if (half == HALF_LAST) begin
                oADC_CS  <= 1'b1;
                oADC_DIN <= 1'b0;
                state    <= S_GAP;
                tmr      <= GAP_LOAD;
`ifdef ADC_SCAN_AVG_EN
                rep <= rep + 2'd1;
                if (rep == 2'd3) begin
                  oDATA  <= acc_sum[RES+1:2];
                  oCH    <= ch;
                  oVALID <= 1'b1;
                  acc    <= '0;
                end else begin
                  acc <= acc_sum;
                end
`else
                oDATA  <= shreg;
                oCH    <= ch;
                oVALID <= 1'b1;
`endif
              end
            end
          end
        end

        S_GAP: begin
          if (tmr != '0) begin
            tmr <= tmr - TMR_ONE;
          end else if (ch_fin && (ch == LAST_CH)) begin
            state      <= S_DONE;
            oSCAN_DONE <= 1'b1;
          end else begin
            state    <= S_FRAME;
            ch       <= next_ch;
            ctrl_sr  <= ctrl_byte(next_ch);
            oADC_CS  <= 1'b0;
            oADC_DIN <= 1'b1;
            tmr      <= DIV_LOAD;
            half     <= '0;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          oBUSY <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_control.sv
`timescale 1ns/1ps
module tb_adc_scan_control;

`ifdef ADC_SCAN_AVG_EN
  localparam int FPC = 4;
`else
  localparam int FPC = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, start0, pen0;
  logic dout0 = 1'b0;
  logic cs0, dclk0, din0, valid0, done0, busy0;
  logic [11:0] data0;
  logic [2:0]  ch0;

  logic rst1, start1, pen1;
  logic dout1 = 1'b0;
  logic cs1, dclk1, din1, valid1, done1, busy1;
  logic [7:0]  data1;
  logic [2:0]  ch1;

  adc_scan_control u0 (
    .iCLK(clk), .iRST(rst0), .iSTART(start0), .iADC_PENIRQ_n(pen0),
    .iADC_BUSY(1'b0), .iADC_DOUT(dout0), .oADC_CS(cs0), .oADC_DCLK(dclk0),
    .oADC_DIN(din0), .oDATA(data0), .oCH(ch0), .oVALID(valid0),
    .oSCAN_DONE(done0), .oBUSY(busy0)
  );

  adc_scan_control #(.NUM_CH(4), .RES(8), .CLK_DIV(4), .GAP_CYC(4)) u1 (
    .iCLK(clk), .iRST(rst1), .iSTART(start1), .iADC_PENIRQ_n(pen1),
    .iADC_BUSY(1'b1), .iADC_DOUT(dout1), .oADC_CS(cs1), .oADC_DCLK(dclk1),
    .oADC_DIN(din1), .oDATA(data1), .oCH(ch1), .oVALID(valid1),
    .oSCAN_DONE(done1), .oBUSY(busy1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int avg_off [4] = '{0, 1, 2, 4};

  // ADC model / monitor state, per instance
  logic [11:0] fval     [2][64];
  logic [7:0]  ctrl_log [2][64];
  int          low_len  [2][64];
  int          gap_len  [2][64];
  logic [11:0] vdata    [2][16];
  logic [2:0]  vch      [2][16];
  int          frm_cnt  [2] = '{0, 0};
  int          vcnt     [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          rise_n   [2] = '{0, 0};
  int          fall_n   [2] = '{0, 0};
  int          lowc     [2] = '{0, 0};
  int          highc    [2] = '{0, 0};
  logic [7:0]  din_sr   [2] = '{8'h0, 8'h0};
  logic        prev_cs  [2] = '{1'b1, 1'b1};
  logic        prev_dclk[2] = '{1'b0, 1'b0};
  logic        dq       [2] = '{1'b0, 1'b0};

  function automatic int res_of(input int k);
    return (k == 0) ? 12 : 8;
  endfunction

  function automatic int nch(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic logic [11:0] expv(input int k, input logic [11:0] base);
    int s;
    int m;
    m = (1 << res_of(k)) - 1;
    if (FPC == 1) return 12'(int'(base) & m);
    s = 0;
    for (int r = 0; r < 4; r++) s += (int'(base) + avg_off[r]) & m;
    return 12'(s >> 2);
  endfunction

  task automatic mon(input int k, input logic cs, input logic dclk, input logic din,
                     input logic valid, input logic [11:0] data, input logic [2:0] ch,
                     input logic done, output logic dout);
    int f;
    int q;
    int idx;
    f = frm_cnt[k];
    if (dclk && !prev_dclk[k]) begin
      rise_n[k]++;
      din_sr[k] = {din_sr[k][6:0], din};
      if (rise_n[k] == 8 && f < 64) ctrl_log[k][f] = din_sr[k];
    end
    if (!dclk && prev_dclk[k]) begin
      fall_n[k]++;
      q = fall_n[k];
      if (q >= 9 && q <= 8 + res_of(k) && f < 64) begin
        idx   = res_of(k) - 1 - (q - 9);
        dq[k] = fval[k][f][idx];
      end else begin
        dq[k] = 1'b0;
      end
    end
    if (cs) begin
      if (!prev_cs[k]) begin
        if (f < 64) low_len[k][f] = lowc[k];
        frm_cnt[k]++;
        highc[k] = 0;
      end
      highc[k]++;
    end else begin
      if (prev_cs[k]) begin
        if (f < 64) gap_len[k][f] = highc[k];
        lowc[k]   = 0;
        rise_n[k] = 0;
        fall_n[k] = 0;
        din_sr[k] = 8'h0;
      end
      lowc[k]++;
    end
    if (valid && vcnt[k] < 16) begin
      vdata[k][vcnt[k]] = data;
      vch[k][vcnt[k]]   = ch;
      vcnt[k]++;
    end
    if (done) done_cnt[k]++;
    prev_cs[k]   = cs;
    prev_dclk[k] = dclk;
    dout = dq[k];
  endtask

  always @(negedge clk) begin
    mon(0, cs0, dclk0, din0, valid0, data0, ch0, done0, dout0);
    mon(1, cs1, dclk1, din1, valid1, {4'h0, data1}, ch1, done1, dout1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_vals(input int k, input int fb, input logic [11:0] b [4]);
    int idx;
    for (int c = 0; c < nch(k); c++)
      for (int r = 0; r < FPC; r++) begin
        idx = fb + c * FPC + r;
        if (idx < 64) fval[k][idx] = 12'((int'(b[c]) + avg_off[r]) & ((1 << res_of(k)) - 1));
      end
  endtask

  task automatic wait_done(input int k, input int db);
    int n;
    n = 0;
    while (done_cnt[k] == db && n < 30000) begin
      @(posedge clk);
      n++;
    end
    chk("scan_done_timeout", 32'(done_cnt[k] != db), 32'd1);
    step(3);
  endtask

  logic [11:0] vals [4];
  logic [7:0]  ctrl_exp1 [4] = '{8'h98, 8'hD8, 8'hA8, 8'hE8};
  int fb, vb, db, n;

  initial begin
    rst0 = 1'b1; start0 = 1'b0; pen0 = 1'b1;
    rst1 = 1'b1; start1 = 1'b0; pen1 = 1'b1;
    step(3);
    chk("rst_cs",    32'(cs0),    32'd1);
    chk("rst_dclk",  32'(dclk0),  32'd0);
    chk("rst_din",   32'(din0),   32'd0);
    chk("rst_data",  32'(data0),  32'd0);
    chk("rst_ch",    32'(ch0),    32'd0);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_done",  32'(done0),  32'd0);
    chk("rst_busy",  32'(busy0),  32'd0);
    chk("rst_cs_u1", 32'(cs1),    32'd1);
    rst0 = 1'b0; rst1 = 1'b0;
    step(2);

    // Host start, both channels 0x7FF
    fb = frm_cnt[0]; vb = vcnt[0]; db = done_cnt[0];
    vals = '{12'h7FF, 12'h7FF, 12'h0, 12'h0};
    set_vals(0, fb, vals);
    start0 = 1'b1; step(1); start0 = 1'b0;
    chk("t1_cs_fall", 32'(cs0),   32'd0);
    chk("t1_busy",    32'(busy0), 32'd1);
    wait_done(0, db);
    chk("t1_frames", 32'(frm_cnt[0] - fb), 32'(2 * FPC));
    chk("t1_nvalid", 32'(vcnt[0] - vb),    32'd2);
    chk("t1_data0",  32'(vdata[0][vb]),    32'(expv(0, 12'h7FF)));
    chk("t1_ch0",    32'(vch[0][vb]),      32'd0);
    chk("t1_data1",  32'(vdata[0][vb+1]),  32'(expv(0, 12'h7FF)));
    chk("t1_ch1",    32'(vch[0][vb+1]),    32'd1);
    chk("t1_ctrl0",  32'(ctrl_log[0][fb]),       32'h90);
    chk("t1_ctrl1",  32'(ctrl_log[0][fb+FPC]),   32'hD0);
    chk("t1_len",    32'(low_len[0][fb]),        32'd1200);
    chk("t1_gap",    32'(gap_len[0][fb+FPC]),    32'd4);
    chk("t1_ndone",  32'(done_cnt[0] - db),      32'd1);
    chk("t1_busy_low", 32'(busy0), 32'd0);

    // Pen-down pulse of one cycle
    fb = frm_cnt[0]; vb = vcnt[0]; db = done_cnt[0];
    vals = '{12'h155, 12'hA01, 12'h0, 12'h0};
    set_vals(0, fb, vals);
    pen0 = 1'b0; step(1); pen0 = 1'b1;
    n = 1;
    while (cs0 && n < 50) begin
      step(1);
      n++;
    end
    chk("t2_latency", 32'(n), 32'd3);
    wait_done(0, db);
    chk("t2_data0", 32'(vdata[0][vb]),   32'(expv(0, 12'h155)));
    chk("t2_data1", 32'(vdata[0][vb+1]), 32'(expv(0, 12'hA01)));
    chk("t2_ch1",   32'(vch[0][vb+1]),   32'd1);
    chk("t2_len_first", 32'(low_len[0][fb]),             32'd1200);
    chk("t2_len_last",  32'(low_len[0][fb+2*FPC-1]),     32'd1200);
    chk("t2_ndone", 32'(done_cnt[0] - db), 32'd1);

    // RES=8, four channels
    fb = frm_cnt[1]; vb = vcnt[1]; db = done_cnt[1];
    vals = '{12'h00, 12'hFF, 12'hA5, 12'h5A};
    set_vals(1, fb, vals);
    start1 = 1'b1; step(1); start1 = 1'b0;
    wait_done(1, db);
    chk("t3_nvalid", 32'(vcnt[1] - vb),    32'd4);
    chk("t3_frames", 32'(frm_cnt[1] - fb), 32'(4 * FPC));
    for (int c = 0; c < 4; c++) begin
      chk("t3_ctrl", 32'(ctrl_log[1][fb+c*FPC]), 32'(ctrl_exp1[c]));
      chk("t3_data", 32'(vdata[1][vb+c]),        32'(expv(1, vals[c])));
      chk("t3_ch",   32'(vch[1][vb+c]),          32'(c));
    end
    chk("t3_gap1", 32'(gap_len[1][fb+FPC]),   32'd4);
    chk("t3_gap3", 32'(gap_len[1][fb+3*FPC]), 32'd4);
    chk("t3_len",  32'(low_len[1][fb]),       32'd192);

    // Reset during DCLK period 12 of the first frame
    vb = vcnt[0];
    start0 = 1'b1; step(1); start0 = 1'b0;
    step(2);
    n = 0;
    while (rise_n[0] < 13 && n < 2000) begin
      step(1);
      n++;
    end
    chk("t4_reach_p12", 32'(rise_n[0] >= 13), 32'd1);
    rst0 = 1'b1; step(1);
    chk("t4_cs",    32'(cs0),    32'd1);
    chk("t4_dclk",  32'(dclk0),  32'd0);
    chk("t4_valid", 32'(valid0), 32'd0);
    chk("t4_busy",  32'(busy0),  32'd0);
    rst0 = 1'b0; step(5);
    chk("t4_no_partial", 32'(vcnt[0] - vb), 32'd0);
    fb = frm_cnt[0]; vb = vcnt[0]; db = done_cnt[0];
    vals = '{12'h3C3, 12'h0F0, 12'h0, 12'h0};
    set_vals(0, fb, vals);
    start0 = 1'b1; step(1); start0 = 1'b0;
    wait_done(0, db);
    chk("t4_data0", 32'(vdata[0][vb]),   32'(expv(0, 12'h3C3)));
    chk("t4_data1", 32'(vdata[0][vb+1]), 32'(expv(0, 12'h0F0)));
    chk("t4_ctrl0", 32'(ctrl_log[0][fb]), 32'h90);

    // Repeated iSTART during a scan
    fb = frm_cnt[1]; db = done_cnt[1];
    start1 = 1'b1; step(1); start1 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(9);
      start1 = 1'b1; step(1); start1 = 1'b0;
    end
    wait_done(1, db);
    step(20);
    chk("t5_ndone",  32'(done_cnt[1] - db), 32'd1);
    chk("t5_frames", 32'(frm_cnt[1] - fb),  32'(4 * FPC));
    chk("t5_idle_cs", 32'(cs1),  32'd1);
    chk("t5_busy",    32'(busy1), 32'd0);

    // iSTART with pen-down in the same cycle
    fb = frm_cnt[1]; db = done_cnt[1];
    start1 = 1'b1; pen1 = 1'b0; step(1); start1 = 1'b0; pen1 = 1'b1;
    wait_done(1, db);
    step(20);
    chk("t6_ndone",  32'(done_cnt[1] - db), 32'd1);
    chk("t6_frames", 32'(frm_cnt[1] - fb),  32'(4 * FPC));
    chk("t6_idle_cs", 32'(cs1), 32'd1);

`ifdef ADC_SCAN_AVG_EN
    // Averaging: 0x100, 0x101, 0x102, 0x104 on ch0
    fb = frm_cnt[0]; vb = vcnt[0]; db = done_cnt[0];
    vals = '{12'h100, 12'h200, 12'h0, 12'h0};
    set_vals(0, fb, vals);
    start0 = 1'b1; step(1); start0 = 1'b0;
    wait_done(0, db);
    chk("avg_data0",  32'(vdata[0][vb]), 32'h101);
    chk("avg_ch0",    32'(vch[0][vb]),   32'd0);
    chk("avg_nvalid", 32'(vcnt[0] - vb), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
